load_unit_ctrl: RTL and testbench

Sequences every CPU load through the Avalon-style data-memory port and merges the returned word into the architectural result. Covers LB, LBU, LH, LHU, LW, LWL and LWR, including the partial-register merge with the old rt value. Sits between the decode/execute stage and the data-memory bus; the CPU stalls while `req_ready` is low. Enforces alignment and bus-timeout rules.

---
 rtl/load_pkg.sv | 43 ++++
 rtl/load_merge.sv | 39 +++
 rtl/load_unit_ctrl.sv | 130 +++++++++++++
 tb/tb_load_unit_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
`default_nettype none
// Shared opcode/state types and request-decoding helpers for the CPU load path.
package load_pkg;

   localparam int LANES = 4;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LBU = 3'b001,
      LH  = 3'b010,
      LHU = 3'b011,
      LW  = 3'b100,
      LWL = 3'b101,
      LWR = 3'b110,
      RSV = 3'b111
   } load_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } load_state_e;

   // A request that never reaches the bus: misaligned halfword/word or reserved opcode.
   function automatic logic is_illegal(load_op_e op, logic [1:0] off);
      case (op)
         LH, LHU: return off[0];
         LW:      return (off != 2'd0);
         RSV:     return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [LANES-1:0] lane_enable(load_op_e op, logic [1:0] off);
      case (op)
         LB, LBU: return LANES'(1) << off;
         LH, LHU: return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_merge.sv
`default_nettype none
// Combinational merge of a returned memory word with the old rt value for every load flavour.
module load_merge
   import load_pkg::*;
(
   input  load_op_e    op_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] word_i,
   input  logic [31:0] rt_i,
   output logic [31:0] result_o
);

   logic [4:0]  sh_lo;
   logic [4:0]  sh_hi;
   logic [7:0]  byte_w;
   logic [15:0] half_w;

   assign sh_lo  = {offset_i, 3'b000};
   assign sh_hi  = {2'd3 - offset_i, 3'b000};
   assign byte_w = 8'(word_i >> sh_lo);
   assign half_w = 16'(word_i >> sh_lo);

   always_comb begin
      result_o = '0;
      case (op_i)
         LB:      result_o = {{24{byte_w[7]}}, byte_w};
         LBU:     result_o = {24'h0, byte_w};
         LH:      result_o = {{16{half_w[15]}}, half_w};
         LHU:     result_o = {16'h0, half_w};
         LW:      result_o = word_i;
         // Unaligned-word pair: memory bytes fill the high (LWL) or low (LWR) end, rt keeps the rest.
         LWL:     result_o = (word_i << sh_hi) | (rt_i & ~(32'hFFFF_FFFF << sh_hi));
         LWR:     result_o = (word_i >> sh_lo) | (rt_i & ~(32'hFFFF_FFFF >> sh_lo));
         default: result_o = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_unit_ctrl.sv
`default_nettype none
// Load sequencer: accepts one load, runs a single Avalon read with timeout, returns the merged result.
module load_unit_ctrl
   import load_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_rt,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic [3:0]  mem_byteenable,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err
);

   localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_CYCLES);

   load_state_e    state_q;
   load_op_e       op_q;
   load_op_e       op_in;
   logic [1:0]     off_q;
   logic [31:0]    rt_q;
   logic [CW-1:0]  wait_q;
   logic           req_ready_q;
   logic           mem_read_q;
   logic [31:0]    mem_address_q;
   logic [3:0]     mem_be_q;
   logic           resp_valid_q;
   logic [31:0]    resp_data_q;
   logic           resp_err_q;
   logic [31:0]    merged_d;

   assign op_in = load_op_e'(req_op);

   load_merge u_merge (
      .op_i     (op_q),
      .offset_i (off_q),
      .word_i   (mem_readdata),
      .rt_i     (rt_q),
      .result_o (merged_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         op_q          <= LB;
         off_q         <= 2'd0;
         rt_q          <= '0;
         wait_q        <= '0;
         req_ready_q   <= 1'b1;
         mem_read_q    <= 1'b0;
         mem_address_q <= '0;
         mem_be_q      <= '0;
         resp_valid_q  <= 1'b0;
         resp_data_q   <= '0;
         resp_err_q    <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  op_q        <= op_in;
                  off_q       <= req_addr[1:0];
                  rt_q        <= req_rt;
                  req_ready_q <= 1'b0;
                  if (is_illegal(op_in, req_addr[1:0])) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_data_q  <= '0;
                  end else begin
                     state_q       <= READ;
                     wait_q        <= '0;
                     mem_read_q    <= 1'b1;
                     mem_address_q <= {req_addr[31:2], 2'b00};
                     mem_be_q      <= lane_enable(op_in, req_addr[1:0]);
                  end
               end
            end
            READ: begin
               // A completing transfer wins over a simultaneous timeout.
               if (!mem_waitrequest) begin
                  state_q      <= RESP;
                  mem_read_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_data_q  <= merged_d;
               end else if (wait_q == TIMEOUT_C) begin
                  state_q      <= RESP;
                  mem_read_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_data_q  <= '0;
               end else begin
                  wait_q <= wait_q + CW'(1);
               end
            end
            RESP: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               mem_read_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign mem_read       = mem_read_q;
   assign mem_address    = mem_address_q;
   assign mem_byteenable = mem_be_q;
   assign resp_valid     = resp_valid_q;
   assign resp_data      = resp_data_q;
   assign resp_err       = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_unit_ctrl.sv
`default_nettype none
// Bench for load_unit_ctrl: byte-level result model plus per-transaction cycle timeline, checked every cycle.
`timescale 1ns/1ps
module tb_load_unit_ctrl;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_rt;
   logic [31:0] mem_address;
   logic        mem_read;
   logic [3:0]  mem_byteenable;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;

   always #5 clk = ~clk;

   load_unit_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_addr        (req_addr),
      .req_rt          (req_rt),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_byteenable  (mem_byteenable),
      .mem_waitrequest (mem_waitrequest),
      .mem_readdata    (mem_readdata),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .resp_err        (resp_err)
   );

   int nchecks = 0;
   int nerrors = 0;
   int cyc = 0;

   logic        chk_en = 1'b0;
   logic        e_ready, e_read, e_valid, e_err, e_bus;
   logic [31:0] e_data, e_addr;
   logic [3:0]  e_be;
   logic [31:0] held_data;
   logic        held_err;
   logic [31:0] last_resp;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   // Reference: result assembled byte by byte from the little-endian lane rules.
   function automatic logic [31:0] model_result(input logic [2:0] op, input logic [1:0] o,
                                                input logic [31:0] w, input logic [31:0] r);
      logic [7:0] wb[4];
      logic [7:0] res[4];
      int oi;
      logic [7:0] ext;
      oi = int'(o);
      for (int k = 0; k < 4; k++) begin
         wb[k]  = w[8*k +: 8];
         res[k] = r[8*k +: 8];
      end
      case (op)
         3'd0, 3'd1: begin
            ext = (op == 3'd0 && wb[oi][7]) ? 8'hFF : 8'h00;
            res[0] = wb[oi];
            for (int k = 1; k < 4; k++) res[k] = ext;
         end
         3'd2, 3'd3: begin
            ext = (op == 3'd2 && wb[oi+1][7]) ? 8'hFF : 8'h00;
            res[0] = wb[oi];
            res[1] = wb[oi+1];
            res[2] = ext;
            res[3] = ext;
         end
         3'd4: for (int k = 0; k < 4; k++) res[k] = wb[k];
         3'd5: for (int k = 0; k < 4; k++) if (k >= 3 - oi) res[k] = wb[k-(3-oi)];
         3'd6: for (int k = 0; k < 4; k++) if (k <= 3 - oi) res[k] = wb[k+oi];
         default: for (int k = 0; k < 4; k++) res[k] = 8'h00;
      endcase
      return {res[3], res[2], res[1], res[0]};
   endfunction

   function automatic logic model_illegal(input logic [2:0] op, input logic [1:0] o);
      return (op == 3'd7) || ((op == 3'd2 || op == 3'd3) && o[0]) || (op == 3'd4 && o != 2'd0);
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] op, input logic [1:0] o);
      logic [3:0] be;
      be = 4'b0000;
      if (op <= 3'd1) be[o] = 1'b1;
      else if (op <= 3'd3) begin
         be[o] = 1'b1;
         be[o+1] = 1'b1;
      end else be = 4'b1111;
      return be;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         check32("req_ready", 32'(req_ready), 32'(e_ready));
         check32("mem_read", 32'(mem_read), 32'(e_read));
         check32("resp_valid", 32'(resp_valid), 32'(e_valid));
         check32("resp_data", resp_data, e_data);
         check32("resp_err", 32'(resp_err), 32'(e_err));
         if (e_bus) begin
            check32("mem_address", mem_address, e_addr);
            check32("mem_byteenable", 32'(mem_byteenable), 32'(e_be));
         end
      end
      if (resp_valid) last_resp = resp_data;
   end

   task automatic idle_cycle();
      reset           = 1'b0;
      req_valid       = 1'b0;
      req_op          = 3'($urandom);
      req_addr        = $urandom;
      req_rt          = $urandom;
      mem_waitrequest = 1'($urandom);
      mem_readdata    = $urandom;
      e_ready = 1'b1; e_read = 1'b0; e_valid = 1'b0; e_bus = 1'b0;
      e_data  = held_data; e_err = held_err;
      @(posedge clk); #1;
   endtask

   // One load; the slave holds waitrequest for nwait cycles (nwait > T forces a timeout).
   task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] w, input int nwait, input int gap);
      logic ill;
      logic tmo;
      int   L;
      int   R;
      logic [31:0] res;
      repeat (gap) idle_cycle();
      ill = model_illegal(op, addr[1:0]);
      tmo = !ill && (nwait > T);
      L   = ill ? 0 : (tmo ? T + 1 : nwait + 1);
      R   = L + 1;
      res = (ill || tmo) ? 32'h0 : model_result(op, addr[1:0], w, rt);
      for (int j = 0; j <= R; j++) begin
         reset = 1'b0;
         if (j == 0) begin
            req_valid = 1'b1; req_op = op; req_addr = addr; req_rt = rt;
         end else begin
            req_valid = 1'($urandom); req_op = 3'($urandom); req_addr = $urandom; req_rt = $urandom;
         end
         mem_waitrequest = (j >= 1 && j <= L) ? ((j - 1) < nwait) : 1'($urandom);
         mem_readdata    = (!ill && !tmo && j == L) ? w : $urandom;
         e_ready = (j == 0);
         e_read  = (j >= 1 && j <= L);
         e_valid = (j == R);
         if (j == R) begin
            held_data = res;
            held_err  = ill || tmo;
         end
         e_data = held_data;
         e_err  = held_err;
         e_bus  = e_read;
         e_addr = {addr[31:2], 2'b00};
         e_be   = model_be(op, addr[1:0]);
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_mid_read(input logic [31:0] addr);
      for (int j = 0; j <= 3; j++) begin
         req_valid = (j == 0) ? 1'b1 : 1'($urandom);
         req_op = 3'd4; req_addr = addr; req_rt = $urandom;
         mem_waitrequest = 1'b1;
         mem_readdata = $urandom;
         reset = (j == 2);
         e_ready = (j == 0) || (j == 3);
         e_read  = (j == 1) || (j == 2);
         e_valid = 1'b0;
         if (j == 3) begin
            held_data = '0;
            held_err  = 1'b0;
         end
         e_data = held_data; e_err = held_err;
         e_bus  = (j >= 1);
         e_addr = (j == 3) ? 32'h0 : addr;
         e_be   = (j == 3) ? 4'h0 : 4'hF;
         if (j == 3) req_valid = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_rt = '0;
      mem_waitrequest = 1'b0; mem_readdata = '0;
      held_data = '0; held_err = 1'b0; last_resp = '0;
      repeat (2) @(posedge clk);
      #1;
      e_ready = 1'b1; e_read = 1'b0; e_valid = 1'b0; e_data = '0; e_err = 1'b0;
      e_bus = 1'b1; e_addr = '0; e_be = '0;
      chk_en = 1'b1;
      @(posedge clk); #1;
      idle_cycle();

      check32("model_lb", model_result(3'd0, 2'd3, 32'h80112233, 32'h0), 32'hFFFFFF80);
      check32("model_lbu", model_result(3'd1, 2'd3, 32'h80112233, 32'h0), 32'h00000080);
      check32("model_lwl", model_result(3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344), 32'hCCDD3344);
      check32("model_lwr", model_result(3'd6, 2'd1, 32'hAABBCCDD, 32'h11223344), 32'h11AABBCC);
      check32("model_lh", model_result(3'd2, 2'd2, 32'h8001_7FFF, 32'h0), 32'hFFFF8001);

      do_load(3'd4, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
      check32("lw_result", last_resp, 32'hDEADBEEF);
      do_load(3'd0, 32'h103, 32'h0, 32'h80112233, 0, 1);
      check32("lb_result", last_resp, 32'hFFFFFF80);
      do_load(3'd1, 32'h103, 32'h0, 32'h80112233, 0, 0);
      check32("lbu_result", last_resp, 32'h00000080);
      do_load(3'd5, 32'h201, 32'h11223344, 32'hAABBCCDD, 0, 0);
      check32("lwl_result", last_resp, 32'hCCDD3344);
      do_load(3'd6, 32'h201, 32'h11223344, 32'hAABBCCDD, 0, 0);
      check32("lwr_result", last_resp, 32'h11AABBCC);
      do_load(3'd2, 32'h301, 32'h0, 32'h12345678, 0, 0);
      check32("lh_misaligned_err", 32'(resp_err), 32'h1);
      do_load(3'd4, 32'h400, 32'h0, 32'h12345678, 1000, 1);
      check32("timeout_err", 32'(resp_err), 32'h1);
      do_load(3'd4, 32'h404, 32'h0, 32'hCAFEF00D, 3, 0);
      check32("wait3_result", last_resp, 32'hCAFEF00D);
      do_load(3'd7, 32'h500, 32'h0, 32'h0, 0, 0);
      reset_mid_read(32'h600);
      repeat (4) idle_cycle();

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
         do_load(3'($urandom_range(0, 7)), a, $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 2) : 0,
                 $urandom_range(0, 2));
      end
      repeat (3) idle_cycle();
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
`default_nettype wire
